sb_loopback_fifo: RTL and testbench



---
 rtl/sb_loopback_fifo_pkg.sv | 23 ++
 rtl/sb_byte_xform.sv | 21 ++
 rtl/sb_loopback_fifo.sv | 94 +++++++++
 tb/tb_sb_loopback_fifo.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_loopback_fifo_pkg.sv
// Shared constants and the per-byte transform used by the loopback FIFO.
// Mode encodings select how each payload byte is rewritten on the write path.
package sb_loopback_fifo_pkg;

    localparam int SB_LB_MODE_PASS = 0;
    localparam int SB_LB_MODE_ADD  = 1;
    localparam int SB_LB_MODE_XOR  = 2;

    localparam int DEST_W = 32;

    // Unknown modes fall back to pass-through.
    function automatic logic [7:0] xform_byte(input logic [7:0] b, input int mode,
                                              input logic [7:0] operand);
        logic [7:0] r;
        case (mode)
            SB_LB_MODE_ADD: r = b + operand;
            SB_LB_MODE_XOR: r = b ^ operand;
            default:        r = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sb_byte_xform.sv
// Purely combinational per-byte transform; bytes are independent (no carry
// crosses a byte boundary).
module sb_byte_xform
    import sb_loopback_fifo_pkg::*;
#(
    parameter int         DW        = 256,
    parameter int         MODE      = 1,
    parameter logic [7:0] INCREMENT = 8'd1
) (
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    genvar i;
    generate
        for (i = 0; i < DW / 8; i++) begin : g_byte
            assign dout[8*i +: 8] = xform_byte(din[8*i +: 8], MODE, INCREMENT);
        end
    endgenerate

endmodule

// File: rtl/sb_loopback_fifo.sv
// Rate-decoupling echo endpoint: transforms incoming beats, buffers them in a
// DEPTH-entry FIFO and replays them with occupancy and packet-count visibility.
module sb_loopback_fifo
    import sb_loopback_fifo_pkg::*;
#(
    parameter int         DW        = 256,
    parameter int         DEPTH     = 4,
    parameter int         MODE      = 1,
    parameter logic [7:0] INCREMENT = 8'd1,
    parameter int         CW        = 32
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic [DW-1:0]            in_data,
    input  logic [DEST_W-1:0]        in_dest,
    input  logic                     in_last,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DW-1:0]            out_data,
    output logic [DEST_W-1:0]        out_dest,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CW-1:0]            pkt_count
);

    // Handshake: a beat moves when valid & ready are both high at a rising
    // edge; a source holds its beat stable until that happens.

    localparam int AW      = $clog2(DEPTH);
    localparam int PW      = AW + 1;
    localparam int ENTRY_W = DW + DEST_W + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               ready_en;
    logic [DW-1:0]      xdata;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    sb_byte_xform #(
        .DW        (DW),
        .MODE      (MODE),
        .INCREMENT (INCREMENT)
    ) u_xform (
        .din  (in_data),
        .dout (xdata)
    );

    // MSB of each pointer is the wrap bit that separates full from empty.
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);

    // ready_en keeps in_ready low while held in reset without sampling nreset
    // combinationally; in_ready never depends on out_ready.
    assign in_ready  = ready_en && !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign level     = wr_ptr - rd_ptr;

    assign {out_data, out_dest, out_last} = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {xdata, in_dest, in_last};
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ready_en  <= 1'b0;
            pkt_count <= '0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (out_last) begin
                    pkt_count <= pkt_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sb_loopback_fifo.sv
// Self-checking bench for sb_loopback_fifo: four instances share one stimulus
// stream (ADD, XOR 0xA5, pass-through, and a 4-bit packet counter).
module tb_sb_loopback_fifo;

    localparam int DW = 256;

    typedef struct {
        logic [DW-1:0] data;
        logic [31:0]   dest;
        logic          last;
        logic [DW-1:0] exp_data;
    } vec_t;

    logic          clk = 1'b0;
    logic          nreset;
    logic [DW-1:0] in_data;
    logic [31:0]   in_dest;
    logic          in_last;
    logic          in_valid;
    logic          out_ready;

    logic          in_ready, x_in_ready, p_in_ready, c_in_ready;
    logic [DW-1:0] out_data, x_out_data, p_out_data, c_out_data;
    logic [31:0]   out_dest, x_out_dest, p_out_dest, c_out_dest;
    logic          out_last, x_out_last, p_out_last, c_out_last;
    logic          out_valid, x_out_valid, p_out_valid, c_out_valid;
    logic [2:0]    level, x_level, p_level, c_level;
    logic [31:0]   pkt_count, x_pkt_count, p_pkt_count;
    logic [3:0]    c_pkt_count;

    int n_checks = 0;
    int n_errors = 0;
    int sent_pkts = 0;
    int cyc = 0;
    logic [DW+32:0] exp_q[$];
    vec_t vecs[5];

    sb_loopback_fifo #(.DW(DW), .DEPTH(4), .MODE(1), .INCREMENT(8'd1), .CW(32)) dut (
        .clk(clk), .nreset(nreset), .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_dest(out_dest),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready), .level(level),
        .pkt_count(pkt_count));

    sb_loopback_fifo #(.DW(DW), .DEPTH(4), .MODE(2), .INCREMENT(8'hA5), .CW(32)) dut_xor (
        .clk(clk), .nreset(nreset), .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
        .in_valid(in_valid), .in_ready(x_in_ready), .out_data(x_out_data), .out_dest(x_out_dest),
        .out_last(x_out_last), .out_valid(x_out_valid), .out_ready(out_ready), .level(x_level),
        .pkt_count(x_pkt_count));

    sb_loopback_fifo #(.DW(DW), .DEPTH(4), .MODE(0), .INCREMENT(8'h3C), .CW(32)) dut_pass (
        .clk(clk), .nreset(nreset), .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
        .in_valid(in_valid), .in_ready(p_in_ready), .out_data(p_out_data), .out_dest(p_out_dest),
        .out_last(p_out_last), .out_valid(p_out_valid), .out_ready(out_ready), .level(p_level),
        .pkt_count(p_pkt_count));

    sb_loopback_fifo #(.DW(DW), .DEPTH(4), .MODE(1), .INCREMENT(8'd1), .CW(4)) dut_cw4 (
        .clk(clk), .nreset(nreset), .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
        .in_valid(in_valid), .in_ready(c_in_ready), .out_data(c_out_data), .out_dest(c_out_dest),
        .out_last(c_out_last), .out_valid(c_out_valid), .out_ready(out_ready), .level(c_level),
        .pkt_count(c_pkt_count));

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input int mode,
                                            input logic [7:0] k);
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 8; i++) begin
            if (mode == 1)      r[8*i +: 8] = d[8*i +: 8] + k;
            else if (mode == 2) r[8*i +: 8] = d[8*i +: 8] ^ k;
            else                r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: observes handshakes at the falling edge; they take effect
    // at the following rising edge.
    always @(negedge clk) begin
        logic [DW+32:0] e;
        if (nreset === 1'b1 && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_add_data", out_data, model(e[DW+32:33], 1, 8'd1));
                check("sb_xor_data", x_out_data, model(e[DW+32:33], 2, 8'hA5));
                check("sb_pass_data", p_out_data, e[DW+32:33]);
                check("sb_dest", out_dest, e[32:1]);
                check("sb_last", out_last, e[0]);
            end
        end
        if (nreset === 1'b1 && in_valid && in_ready) begin
            exp_q.push_back({in_data, in_dest, in_last});
        end
    end

    // Driver tasks: called just after a rising edge.
    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Leaves in_valid high so back-to-back calls stream without bubbles.
    task automatic send_beat(input logic [DW-1:0] d, input logic [31:0] dest, input logic last);
        int n;
        logic ok;
        in_data  = d;
        in_dest  = dest;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            n++;
        end while (!ok && n < 64);
        if (!ok) check("send_timeout", 0, 1);
        if (last) sent_pkts++;
        align();
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
        check("drain_valid", out_valid, 0);
        check("drain_level", level, 0);
        align();
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        int exp_pk;
        int nbeats;
        int start;
        int len;

        vecs[0] = '{{32{8'hFF}}, 32'd7, 1'b1, {32{8'h00}}};
        vecs[1] = '{256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100, 32'd3, 1'b0,
                    256'h201f1e1d1c1b1a191817161514131211100f0e0d0c0b0a090807060504030201};
        vecs[2] = '{{32{8'h00}}, 32'hDEADBEEF, 1'b1, {32{8'h01}}};
        vecs[3] = '{{16{16'h7F80}}, 32'd1, 1'b0, {16{16'h8081}}};
        vecs[4] = '{{32{8'hFE}}, 32'hFFFF_FFFF, 1'b1, {32{8'hFF}}};

        nreset = 1'b0; in_valid = 1'b0; in_data = '0; in_dest = '0; in_last = 1'b0;
        out_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_level", level, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_pkt_count", pkt_count, 0);
        nreset = 1'b1;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);
        check("rel_level", level, 0);

        // Table-driven single beats: 1-cycle latency and the ADD transform.
        out_ready = 1'b1;
        align();
        exp_pk = 0;
        for (int i = 0; i < 5; i++) begin
            send_beat(vecs[i].data, vecs[i].dest, vecs[i].last);
            idle();
            @(negedge clk);
            check("vec_valid", out_valid, 1);
            check("vec_data", out_data, vecs[i].exp_data);
            check("vec_xor", x_out_data, vecs[i].data ^ {32{8'hA5}});
            check("vec_pass", p_out_data, vecs[i].data);
            check("vec_dest", out_dest, vecs[i].dest);
            check("vec_last", out_last, vecs[i].last);
            @(negedge clk);
            if (vecs[i].last) exp_pk++;
            check("vec_empty", out_valid, 0);
            check("vec_pkt_count", pkt_count, exp_pk);
            align();
        end

        // Backpressure: fill to DEPTH, stall the 5th, then release.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_beat(rand_data(), 100 + k, k == 3);
        idle();
        @(negedge clk);
        check("full_level", level, 4);
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        align();
        in_data = rand_data(); in_dest = 104; in_last = 1'b0; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_level", level, 4);
        align();
        out_ready = 1'b1;
        send_beat(in_data, 104, 1'b0);
        send_beat(rand_data(), 105, 1'b1);
        idle();
        drain();

        // Full FIFO, continuous traffic: one beat per cycle.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_beat(rand_data(), 200 + k, 1'b1);
        idle();
        out_ready = 1'b1;
        start = cyc;
        nbeats = 0;
        for (int p = 0; p < 100; p++) begin
            len = $urandom_range(1, 3);
            for (int b = 0; b < len; b++) begin
                send_beat(rand_data(), $urandom, b == len - 1);
                nbeats++;
            end
        end
        idle();
        check("throughput_cycles", (cyc - start) <= nbeats + 1, 1);
        drain();
        check("pkt_count_total", pkt_count, sent_pkts);
        check("pkt_count_cw4", c_pkt_count, sent_pkts % 16);

        // Reset mid-packet with 3 stored beats.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) send_beat(rand_data(), 300 + k, 1'b0);
        idle();
        @(negedge clk);
        check("mid_level", level, 3);
        #2;
        nreset = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_pkt", pkt_count, 0);
        check("mid_rst_in_ready", in_ready, 0);
        exp_q.delete();
        sent_pkts = 0;
        @(negedge clk);
        nreset = 1'b1;
        align();
        out_ready = 1'b1;
        send_beat({32{8'h42}}, 32'd9, 1'b1);
        idle();
        @(negedge clk);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_level", level, 1);
        check("post_rst_data", out_data, {32{8'h43}});
        @(negedge clk);
        check("post_rst_alone", out_valid, 0);
        align();

        // Counter wrap: 17 single-beat packets on a 4-bit counter.
        for (int k = 0; k < 16; k++) send_beat(rand_data(), 400 + k, 1'b1);
        idle();
        drain();
        check("wrap_pkt32", pkt_count, 17);
        check("wrap_pkt4", c_pkt_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
